// File: rtl/ext_int_controller_if.sv
// I/O bus and interrupt handshake between the CPU side and the external interrupt controller.
// The master side is the CPU/bus driver; the slave side is the controller.
interface ext_int_controller_if #(
    parameter int NUM_SRC = 8
);
    logic [2:0]         io_dev;
    logic [3:0]         io_reg;
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        wr_data;
    logic [31:0]        rd_data;
    logic [NUM_SRC-1:0] int_src;
    logic               int_req;
    logic               int_ack;

    modport master (
        output io_dev, io_reg, wr_en, rd_en, wr_data, int_src, int_ack,
        input  rd_data, int_req
    );

    modport slave (
        input  io_dev, io_reg, wr_en, rd_en, wr_data, int_src, int_ack,
        output rd_data, int_req
    );
endinterface

// File: rtl/ext_int_controller.sv
// External interrupt controller: edge capture into a pending register, IER masking,
// fixed lowest-index priority and a single in-service interrupt tracked via ack / EOI.
module ext_int_controller #(
    parameter int         NUM_SRC  = 8,
    parameter logic [2:0] DEV_ADDR = 3'h0
) (
    input logic                 clk,
    input logic                 rst,
    ext_int_controller_if.slave bus
);
    localparam logic [3:0] REG_IER = 4'h0;
    localparam logic [3:0] REG_INR = 4'h1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] ier;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] events;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_mask;
    logic [4:0]         int_num;
    logic [4:0]         prio_idx;
    logic               latch_num;
    logic [31:0]        rd_data;
    logic [31:0]        rd_mux;
    logic [31:0]        ier_ext;
    logic               dev_hit;
    logic               ier_wr;
    logic               inr_wr;
    logic               rd_hit;
    logic               wr_data_unused;

    assign dev_hit = (bus.io_dev == DEV_ADDR);
    assign ier_wr  = dev_hit && bus.wr_en && (bus.io_reg == REG_IER);
    assign inr_wr  = dev_hit && bus.wr_en && (bus.io_reg == REG_INR);
    assign rd_hit  = dev_hit && bus.rd_en;

    // Only the low NUM_SRC bits of write data are architected.
    assign wr_data_unused = ^bus.wr_data;

    assign events   = bus.int_src & ~src_prev;
    assign eligible = pending & ier;

    // Scanning downward lets the lowest set index overwrite last and win.
    always_comb begin
        prio_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) prio_idx = 5'(i);
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        latch_num = 1'b0;
        clr_mask  = '0;
        unique case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = REQ;
                    latch_num = 1'b1;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    state_nxt = SERVICE;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (5'(i) == int_num) clr_mask[i] = 1'b1;
                    end
                end
            end
            SERVICE: begin
                if (inr_wr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ier_ext                = '0;
        ier_ext[NUM_SRC-1:0]   = ier;
        rd_mux                 = '0;
        case (bus.io_reg)
            REG_IER: rd_mux = ier_ext;
            REG_INR: rd_mux = {(state != IDLE), 26'b0, int_num};
            default: rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ier      <= '0;
            pending  <= '0;
            src_prev <= '0;
            int_num  <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            src_prev <= bus.int_src;
            // A new edge on the bit being acknowledged keeps it pending.
            pending  <= (pending & ~clr_mask) | events;
            if (ier_wr)    ier     <= bus.wr_data[NUM_SRC-1:0];
            if (latch_num) int_num <= prio_idx;
            if (rd_hit)    rd_data <= rd_mux;
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.int_req = (state == REQ);
endmodule

// File: tb/tb_ext_int_controller.sv
// Directed self-checking bench for ext_int_controller with hand-computed expectations.
module tb_ext_int_controller;
    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_pass;
    logic [31:0] rd;

    ext_int_controller_if #(.NUM_SRC(8)) bus ();

    ext_int_controller #(.NUM_SRC(8), .DEV_ADDR(3'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] dev, input logic [3:0] rg, input logic [31:0] data);
        bus.io_dev  = dev;
        bus.io_reg  = rg;
        bus.wr_data = data;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] dev, input logic [3:0] rg, output logic [31:0] data);
        bus.io_dev = dev;
        bus.io_reg = rg;
        bus.rd_en  = 1'b1;
        tick();
        bus.rd_en  = 1'b0;
        data       = bus.rd_data;
    endtask

    task automatic pulse_src(input int idx);
        bus.int_src[idx] = 1'b1;
        tick();
        bus.int_src[idx] = 1'b0;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        bus.io_dev  = 3'h0;
        bus.io_reg  = 4'h0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        bus.int_src = '0;
        bus.int_ack = 1'b0;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_req", {31'b0, bus.int_req}, 32'h0);
        check("rst_rddata", bus.rd_data, 32'h0);
        bus_read(3'h0, 4'h0, rd);
        check("rst_ier", rd, 32'h0);
        bus_read(3'h0, 4'h1, rd);
        check("rst_inr", rd, 32'h0);

        // First eligible source latched, no preemption by a higher priority arrival
        bus_write(3'h0, 4'h0, 32'h06);
        pulse_src(2);
        pulse_src(1);
        check("req_rise", {31'b0, bus.int_req}, 32'h1);
        bus_read(3'h0, 4'h1, rd);
        check("inr_src2", rd, 32'h8000_0002);
        ack();
        check("req_drop_ack", {31'b0, bus.int_req}, 32'h0);
        bus_read(3'h0, 4'h1, rd);
        check("inr_service", rd, 32'h8000_0002);
        bus_write(3'h0, 4'h1, 32'h0);
        check("eoi_no_req_yet", {31'b0, bus.int_req}, 32'h0);
        tick();
        check("req_after_eoi", {31'b0, bus.int_req}, 32'h1);
        bus_read(3'h0, 4'h1, rd);
        check("inr_src1", rd, 32'h8000_0001);
        ack();
        bus_write(3'h0, 4'h1, 32'h0);

        // Masked event stays pending until IER enables it
        bus_write(3'h0, 4'h0, 32'h0);
        pulse_src(3);
        tick();
        tick();
        check("masked_no_req", {31'b0, bus.int_req}, 32'h0);
        bus_write(3'h0, 4'h0, 32'h08);
        check("ier_wr_plus1", {31'b0, bus.int_req}, 32'h0);
        tick();
        check("ier_wr_plus2", {31'b0, bus.int_req}, 32'h1);
        ack();
        bus_write(3'h0, 4'h1, 32'h0);

        // Level held high for 10 cycles yields one event only
        bus.int_src[3] = 1'b1;
        tick();
        tick();
        check("held_req", {31'b0, bus.int_req}, 32'h1);
        ack();
        for (int i = 0; i < 7; i++) tick();
        bus.int_src[3] = 1'b0;
        bus_write(3'h0, 4'h1, 32'h0);
        tick();
        tick();
        check("held_one_event", {31'b0, bus.int_req}, 32'h0);
        bus_read(3'h0, 4'h1, rd);
        check("inr_idle", rd, 32'h0000_0003);

        // Ack and new edge on the same bit in the same cycle: set wins
        bus_write(3'h0, 4'h0, 32'h10);
        pulse_src(4);
        tick();
        check("req_src4", {31'b0, bus.int_req}, 32'h1);
        bus.int_src[4] = 1'b1;
        bus.int_ack    = 1'b1;
        tick();
        bus.int_src[4] = 1'b0;
        bus.int_ack    = 1'b0;
        check("ack_src4", {31'b0, bus.int_req}, 32'h0);
        bus_write(3'h0, 4'h1, 32'h0);
        tick();
        check("rereq_src4", {31'b0, bus.int_req}, 32'h1);
        bus_read(3'h0, 4'h1, rd);
        check("inr_src4_again", rd, 32'h8000_0004);

        // Reset in SERVICE with a pending event
        ack();
        pulse_src(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req", {31'b0, bus.int_req}, 32'h0);
        bus_read(3'h0, 4'h1, rd);
        check("midrst_inr", rd, 32'h0);
        bus_read(3'h0, 4'h0, rd);
        check("midrst_ier", rd, 32'h0);
        bus_write(3'h0, 4'h0, 32'h10);
        tick();
        tick();
        tick();
        check("midrst_pend_lost", {31'b0, bus.int_req}, 32'h0);

        // Decode, hold, simultaneous access, unmapped offsets
        bus_write(3'h0, 4'h0, 32'h0);
        bus_write(3'h1, 4'h0, 32'hFF);
        bus_read(3'h0, 4'h0, rd);
        check("other_dev_wr", rd, 32'h0);
        bus_read(3'h0, 4'h5, rd);
        check("unmapped_rd", rd, 32'h0);
        bus_write(3'h0, 4'h0, 32'h5A);
        bus_read(3'h0, 4'h0, rd);
        check("ier_5a", rd, 32'h0000_005A);
        bus_read(3'h1, 4'h0, rd);
        check("other_dev_rd_hold", rd, 32'h0000_005A);
        bus.io_dev  = 3'h0;
        bus.io_reg  = 4'h0;
        bus.wr_data = 32'h33;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        check("rw_pre_write", bus.rd_data, 32'h0000_005A);
        bus_write(3'h0, 4'h7, 32'hFFFF);
        bus_read(3'h0, 4'h0, rd);
        check("rw_post_write", rd, 32'h0000_0033);
        check("no_spurious_req", {31'b0, bus.int_req}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
